// File: rtl/axis_route_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : axis_route_ctrl
//  Description : Routing-code controller for a set of vFPGA regions. A
//                route-change request names a target region and a new 8-bit
//                routing code. The controller waits until that region's
//                AXI-Stream taps are quiet, which means no packet in flight on
//                any of its four streams and no tvalid asserted. It then
//                commits the code to io_ctrl[vfid] and issues a one-cycle
//                completion pulse. A request for a non-existent region
//                completes immediately with cpl_err and changes nothing.
//
//  Parameters  : N_ID           - number of regions managed
//                RST_CODE       - routing code loaded into every region on reset
//                TIMEOUT_CYCLES - drain cycles before a forced commit
//                                 (used only with ROUTE_CTRL_TIMEOUT_EN)
//
//  Ports       : aclk, areset            clock, synchronous active-high reset
//                req_valid/req_ready     request handshake
//                req_vfid, req_code      target region and new routing code
//                cpl_valid               one-cycle completion pulse
//                cpl_err, cpl_forced     completion qualifiers
//                mon_tvalid/tready/tlast per-region stream taps
//                                        [region][0 shell_in, 1 shell_out,
//                                                 2 ul_out,   3 ul_in]
//                io_ctrl                 registered routing code per region
//                drain_busy              high while waiting for a quiet region
//
//  Options     : `define ROUTE_CTRL_TIMEOUT_EN adds a drain-cycle counter. When
//                the region is still busy on the TIMEOUT_CYCLES-th drain cycle,
//                the commit is forced and cpl_forced is raised. Without the
//                macro, ST_DRAIN waits indefinitely and cpl_forced is 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_route_ctrl #(
    parameter int         N_ID           = 3,
    parameter logic [7:0] RST_CODE       = 8'h01,
    parameter int         TIMEOUT_CYCLES = 4096,
    localparam int        VFID_W         = (N_ID > 1) ? $clog2(N_ID) : 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    // route-change request
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [VFID_W-1:0]        req_vfid,
    input  logic [7:0]               req_code,
    // completion
    output logic                     cpl_valid,
    output logic                     cpl_err,
    output logic                     cpl_forced,
    // stream taps per region
    input  logic [N_ID-1:0][3:0]     mon_tvalid,
    input  logic [N_ID-1:0][3:0]     mon_tready,
    input  logic [N_ID-1:0][3:0]     mon_tlast,
    // routing codes to the interconnect
    output logic [N_ID-1:0][7:0]     io_ctrl,
    output logic                     drain_busy
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CPL   = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;

    // Latched request
    logic [VFID_W-1:0]     r_vfid;
    logic [7:0]            r_code;
    logic                  r_err;

    // Routing-code registers and stream tracking
    logic [N_ID-1:0][7:0]  r_io_ctrl;
    logic [N_ID-1:0][3:0]  r_inpkt;
    logic [N_ID-1:0]       w_quiet;

    logic                  w_tgt_quiet;
    logic                  w_accept;
    logic                  w_req_oob;
    logic                  w_timeout;
    logic                  w_commit;
    logic                  w_forced;

    assign io_ctrl = r_io_ctrl;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    assign w_accept  = req_valid && (r_state == ST_IDLE);
    // The comparison is widened so that a power-of-two N_ID does not truncate.
    assign w_req_oob = (32'(req_vfid) >= 32'(N_ID));

    // ------------------------------------------------------------------------
    // In-packet tracking. A flag sets on a non-final beat and clears on the
    // final beat, so single-beat packets never set it. The flags track the
    // streams continuously and ignore the FSM state, so the flags are already
    // correct when a request arrives mid-packet.
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_inpkt <= '0;
        end else begin
            for (int i = 0; i < N_ID; i++) begin
                for (int s = 0; s < 4; s++) begin
                    if (mon_tvalid[i][s] && mon_tready[i][s]) begin
                        r_inpkt[i][s] <= ~mon_tlast[i][s];
                    end
                end
            end
        end
    end

    // A region is quiet when nothing is mid-packet and nothing is offered in
    // this cycle. A pending tvalid that is not yet accepted still blocks.
    generate
        for (genvar gi = 0; gi < N_ID; gi++) begin : g_quiet
            assign w_quiet[gi] = ~(|r_inpkt[gi]) & ~(|mon_tvalid[gi]);
        end
    endgenerate

    // Quiet status of the latched target region. ST_DRAIN is only entered
    // with an in-range r_vfid.
    always_comb begin
        w_tgt_quiet = 1'b0;
        for (int i = 0; i < N_ID; i++) begin
            if (r_vfid == VFID_W'(i)) begin
                w_tgt_quiet = w_quiet[i];
            end
        end
    end

    assign w_commit = (r_state == ST_DRAIN) && (w_tgt_quiet || w_timeout);

    // ------------------------------------------------------------------------
    // Optional drain timeout
    // ------------------------------------------------------------------------
`ifdef ROUTE_CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_forced;

    // The counter holds the number of completed drain cycles. It is zero in
    // the first drain cycle, so a value of TIMEOUT_CYCLES-1 marks the
    // TIMEOUT_CYCLES-th drain cycle.
    always_ff @(posedge aclk) begin
        if (areset || (r_state != ST_DRAIN)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_DRAIN) &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // The commit is forced only if the timeout fires while the region is
    // still busy. Hitting the limit on a quiet cycle is a normal commit.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_forced <= 1'b0;
        end else if (w_accept) begin
            r_forced <= 1'b0;
        end else if (w_commit) begin
            r_forced <= ~w_tgt_quiet;
        end
    end

    assign w_forced = r_forced;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_forced         = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    // Out-of-range targets have nothing to drain.
                    w_state_nxt = w_req_oob ? ST_CPL : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_commit) begin
                    w_state_nxt = ST_CPL;
                end
            end
            ST_CPL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. The completion qualifiers are gated by the state so they
    // can never be high without cpl_valid.
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        drain_busy = (r_state == ST_DRAIN);
        cpl_valid  = (r_state == ST_CPL);
        cpl_err    = (r_state == ST_CPL) && r_err;
        cpl_forced = (r_state == ST_CPL) && w_forced;
    end

    // ------------------------------------------------------------------------
    // Request latch and routing-code registers. The code is written on the
    // commit edge, so it is already visible during the ST_CPL cycle. A reset
    // during ST_DRAIN or ST_CPL drops the latched request.
    // ------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_vfid <= '0;
            r_code <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < N_ID; i++) begin
                r_io_ctrl[i] <= RST_CODE;
            end
        end else begin
            if (w_accept) begin
                r_vfid <= req_vfid;
                r_code <= req_code;
                r_err  <= w_req_oob;
            end
            if (w_commit) begin
                for (int i = 0; i < N_ID; i++) begin
                    if (r_vfid == VFID_W'(i)) begin
                        r_io_ctrl[i] <= r_code;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_route_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_route_ctrl
//  Description : Directed scoreboard bench for axis_route_ctrl. Each request
//                pushes its expected completion (cycle, err, forced, io_ctrl)
//                onto a queue. A negedge monitor pops and compares that entry
//                whenever cpl_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_route_ctrl;

    localparam int N_ID   = 3;
    localparam int TO     = 16;
    localparam int VFID_W = 2;

    logic                  aclk;
    logic                  areset;
    logic                  req_valid;
    logic                  req_ready;
    logic [VFID_W-1:0]     req_vfid;
    logic [7:0]            req_code;
    logic                  cpl_valid;
    logic                  cpl_err;
    logic                  cpl_forced;
    logic [N_ID-1:0][3:0]  mon_tvalid;
    logic [N_ID-1:0][3:0]  mon_tready;
    logic [N_ID-1:0][3:0]  mon_tlast;
    logic [N_ID-1:0][7:0]  io_ctrl;
    logic                  drain_busy;

    axis_route_ctrl #(
        .N_ID           (N_ID),
        .RST_CODE       (8'h01),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .aclk       (aclk),
        .areset     (areset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vfid   (req_vfid),
        .req_code   (req_code),
        .cpl_valid  (cpl_valid),
        .cpl_err    (cpl_err),
        .cpl_forced (cpl_forced),
        .mon_tvalid (mon_tvalid),
        .mon_tready (mon_tready),
        .mon_tlast  (mon_tlast),
        .io_ctrl    (io_ctrl),
        .drain_busy (drain_busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        err;
        logic        forced;
        logic [23:0] io;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input int c, input logic e, input logic f, input logic [23:0] io);
        sb.push_back('{cyc: c, err: e, forced: f, io: io});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: compares every completion against the scoreboard head.
    always @(negedge aclk) begin
        if (!areset) begin
            if (cpl_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cpl actual=1 required=0 (t=%0t)", $time);
                end else begin
                    m_e = sb.pop_front();
                    check("cpl_cycle",  cyc,        m_e.cyc);
                    check("cpl_err",    cpl_err,    m_e.err);
                    check("cpl_forced", cpl_forced, m_e.forced);
                    check("cpl_io",     io_ctrl,    m_e.io);
                end
            end else begin
                check("qual_idle", {cpl_err, cpl_forced}, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        areset     = 1'b1;
        req_valid  = 1'b0;
        req_vfid   = '0;
        req_code   = '0;
        mon_tvalid = '0;
        mon_tready = '0;
        mon_tlast  = '0;
        repeat (3) tick();
        areset = 1'b0;

        // Reset state
        @(negedge aclk);
        check("rst_ready", req_ready,  1);
        check("rst_cpl",   cpl_valid,  0);
        check("rst_busy",  drain_busy, 0);
        check("rst_io",    io_ctrl,    24'h010101);

        // Idle region 0 -> completion two cycles after accept
        tick();
        push(cyc + 2, 1'b0, 1'b0, 24'h010102);
        req_valid = 1'b1; req_vfid = 2'd0; req_code = 8'h02;
        tick();
        req_valid = 1'b0;
        @(negedge aclk);
        check("drain_busy_r0", drain_busy, 1);
        check("ready_low_r0",  req_ready,  0);
        wait_drain("drain_r0");

        // Region 1 ul_out mid 8-beat packet; request issued on beat 3
        for (int b = 1; b <= 8; b++) begin
            mon_tvalid[1][2] = 1'b1;
            mon_tready[1][2] = 1'b1;
            mon_tlast[1][2]  = (b == 8);
            if (b == 3) begin
                req_valid = 1'b1; req_vfid = 2'd1; req_code = 8'h03;
            end else begin
                req_valid = 1'b0;
            end
            if (b >= 4) begin
                @(negedge aclk);
                check("pkt_busy", drain_busy, 1);
                check("pkt_hold", io_ctrl[1], 8'h01);
            end
            tick();
        end
        mon_tvalid[1][2] = 1'b0;
        mon_tready[1][2] = 1'b0;
        mon_tlast[1][2]  = 1'b0;
        push(cyc + 1, 1'b0, 1'b0, 24'h010302);
        @(negedge aclk);
        check("pkt_hold_quiet", io_ctrl[1], 8'h01);
        wait_drain("drain_pkt");

        // Region 2 left mid-packet; a request for region 0 is not blocked
        tick();
        mon_tvalid[2][0] = 1'b1; mon_tready[2][0] = 1'b1; mon_tlast[2][0] = 1'b0;
        tick();
        mon_tvalid[2][0] = 1'b0; mon_tready[2][0] = 1'b0;
        push(cyc + 2, 1'b0, 1'b0, 24'h010304);
        req_valid = 1'b1; req_vfid = 2'd0; req_code = 8'h04;
        tick();
        req_valid = 1'b0;
        wait_drain("drain_nontgt");

        // Region 2 request waits for its final beat
        req_valid = 1'b1; req_vfid = 2'd2; req_code = 8'h07;
        tick();
        req_valid = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            check("r2_busy", drain_busy, 1);
            tick();
        end
        mon_tvalid[2][0] = 1'b1; mon_tready[2][0] = 1'b1; mon_tlast[2][0] = 1'b1;
        tick();
        mon_tvalid[2][0] = 1'b0; mon_tready[2][0] = 1'b0; mon_tlast[2][0] = 1'b0;
        push(cyc + 1, 1'b0, 1'b0, 24'h070304);
        wait_drain("drain_r2");

        // Request equal to the current code still completes normally
        push(cyc + 2, 1'b0, 1'b0, 24'h070304);
        req_valid = 1'b1; req_vfid = 2'd0; req_code = 8'h04;
        tick();
        req_valid = 1'b0;
        wait_drain("drain_same");

        // Out-of-range region -> error, nothing changes, no drain
        push(cyc + 1, 1'b1, 1'b0, 24'h070304);
        req_valid = 1'b1; req_vfid = 2'd3; req_code = 8'h05;
        tick();
        req_valid = 1'b0;
        @(negedge aclk);
        check("oob_no_drain", drain_busy, 0);
        wait_drain("drain_oob");

        // Region 0 shell_in offered but never accepted
        mon_tvalid[0][0] = 1'b1; mon_tready[0][0] = 1'b0;
`ifdef ROUTE_CTRL_TIMEOUT_EN
        push(cyc + TO + 1, 1'b0, 1'b1, 24'h070306);
        req_valid = 1'b1; req_vfid = 2'd0; req_code = 8'h06;
        tick();
        req_valid = 1'b0;
        wait_drain("drain_forced");
        mon_tvalid[0][0] = 1'b0;
`else
        req_valid = 1'b1; req_vfid = 2'd0; req_code = 8'h06;
        tick();
        req_valid = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge aclk);
            if (drain_busy) busy_cnt++;
            tick();
        end
        check("hold_1000", busy_cnt, 1000);
        check("hold_io", io_ctrl, 24'h070304);
        mon_tvalid[0][0] = 1'b0;
        push(cyc + 1, 1'b0, 1'b0, 24'h070306);
        wait_drain("drain_release");
`endif

        // Reset in ST_DRAIN drops the request
        mon_tvalid[0][0] = 1'b1; mon_tready[0][0] = 1'b0;
        req_valid = 1'b1; req_vfid = 2'd0; req_code = 8'h09;
        tick();
        req_valid = 1'b0;
        tick();
        @(negedge aclk);
        check("pre_rst_busy", drain_busy, 1);
        tick();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        mon_tvalid[0][0] = 1'b0;
        @(negedge aclk);
        check("post_rst_ready", req_ready,  1);
        check("post_rst_io",    io_ctrl,    24'h010101);
        check("post_rst_busy",  drain_busy, 0);
        repeat (10) tick();
        check("post_rst_sb", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_route_ctrl.md
AXIS_ROUTE_CTRL -- requirements
Module: axis_route_ctrl

Interface
REQ-001 Parameter: N_ID, N_REGIONS, number of vFPGA regions whose routing code is managed.
REQ-002 Parameter: RST_CODE, 8'h01, routing code loaded into every region at reset (pass-through).
REQ-003 Parameter: TIMEOUT_CYCLES, 4096, drain cycles before forced commit (used only with ROUTE_CTRL_TIMEOUT_EN).
REQ-004 Port: aclk  in  1  sole clock; all logic on rising edge.
REQ-005 Port: areset  in  1  reset, synchronous, active-high.
REQ-006 Port: req_valid  in  1  route-change request valid.
REQ-007 Port: req_ready  out  1  request accepted when req_valid & req_ready.
REQ-008 Port: req_vfid  in  clog2s(N_ID)  target region.
REQ-009 Port: req_code  in  8  new routing code.
REQ-010 Port: cpl_valid  out  1  one-cycle completion pulse.
REQ-011 Port: cpl_err  out  1  qualifies cpl_valid; request rejected (vfid >= N_ID).
REQ-012 Port: cpl_forced  out  1  qualifies cpl_valid; commit forced by timeout.
REQ-013 Port: mon_tvalid, mon_tready, mon_tlast  in  [N_ID][4] each  handshake taps per region, stream index 0 shell_in, 1 shell_out, 2 ul_out, 3 ul_in.
REQ-014 Port: io_ctrl  out  [N_ID][8]  registered routing code per region, drives interconnect io_ctrl.
REQ-015 Port: drain_busy  out  1  high while state is ST_DRAIN.

Function
REQ-016 FSM states SHALL be ST_IDLE, ST_DRAIN, ST_CPL; req_ready = 1 only in ST_IDLE.
REQ-017 On accept in ST_IDLE, vfid and code SHALL be latched and the state SHALL go to ST_DRAIN next cycle.
REQ-018 Per region/stream an in-packet flag SHALL set on a beat (tvalid & tready) with tlast=0 and clear on a beat with tlast=1; single-beat packets leave it clear.
REQ-019 Region quiet = all four in-packet flags clear AND all four mon_tvalid low in the same cycle.
REQ-020 In ST_DRAIN, in the first cycle the latched region is quiet, io_ctrl[vfid] SHALL be written with the latched code and the state SHALL go to ST_CPL.
REQ-021 In ST_CPL, cpl_valid = 1 for exactly one cycle with the new io_ctrl already visible; next state ST_IDLE.
REQ-022 Minimum latency accept -> cpl_valid SHALL be 2 cycles.
REQ-023 Request with req_vfid >= N_ID SHALL skip ST_DRAIN, modify no io_ctrl entry, and complete via ST_CPL with cpl_err = 1.
REQ-024 A request equal to the current code SHALL still drain and complete normally.
REQ-025 io_ctrl of non-target regions SHALL never change during a request.
REQ-026 cpl_err and cpl_forced SHALL be 0 whenever cpl_valid = 0.

Reset
REQ-027 On areset: state ST_IDLE, every io_ctrl = RST_CODE, all in-packet flags and timeout counter cleared, cpl_valid/cpl_err/cpl_forced/drain_busy = 0, req_ready = 1 from the first cycle after reset deasserts.
REQ-028 Reset during ST_DRAIN or ST_CPL SHALL drop the pending request with no completion pulse.

Configuration
REQ-029 Macro ROUTE_CTRL_TIMEOUT_EN defined: a counter SHALL count ST_DRAIN cycles; if the region is not quiet by the TIMEOUT_CYCLES-th drain cycle, the commit SHALL occur then and cpl_forced = 1.
REQ-030 Macro undefined: no counter is instantiated; ST_DRAIN waits indefinitely; cpl_forced tied to 0.

Verification
REQ-031 Idle region 0, request vfid=0 code=8'h02 -> cpl_valid 2 cycles after accept, io_ctrl[0]=8'h02, io_ctrl[1]=8'h01, cpl_err=0.
REQ-032 Region 1 ul_out mid 8-beat packet, request vfid=1 code=8'h03 -> io_ctrl[1] unchanged until first quiet cycle after the tlast beat, then 8'h03 with cpl_valid.
REQ-033 Request vfid=N_ID code=8'h05 -> cpl_valid with cpl_err=1, all io_ctrl unchanged.
REQ-034 ROUTE_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, region 0 shell_in tvalid held high, tready low -> commit on 16th drain cycle, cpl_forced=1; without macro -> drain_busy stays 1 for 1000 cycles.
REQ-035 areset asserted during ST_DRAIN -> no cpl_valid, all io_ctrl = 8'h01, req_ready = 1 first cycle after reset release.
